// File: rtl/ula_pkg.sv
// Shared definitions for the ALU-sharing controller: op encodings,
// one-hot ALU control words, FSM state type and the op decode helper.
package ula_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [3:0] CTRL_NONE = 4'b0000;
    localparam logic [3:0] CTRL_ADD  = 4'b0001;
    localparam logic [3:0] CTRL_SUB  = 4'b0010;
    localparam logic [3:0] CTRL_AND  = 4'b0100;
    localparam logic [3:0] CTRL_OR   = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] op_to_ctrl(input logic [1:0] op);
        logic [3:0] ctrl;
        case (op)
            OP_ADD:  ctrl = CTRL_ADD;
            OP_SUB:  ctrl = CTRL_SUB;
            OP_AND:  ctrl = CTRL_AND;
            default: ctrl = CTRL_OR;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/ula_rr_arbitro.sv
// 2-way round-robin grant decision. Purely combinational; the pointer
// register lives in the parent and only moves on response completion.
module ula_rr_arbitro (
    input  logic valid0,
    input  logic valid1,
    input  logic ptr,
    output logic grant_id,
    output logic grant_valid
);

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = 1'b0;
        if (valid0 && valid1) begin
            grant_id = ptr;
        end else if (valid1) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/ula_arbitro.sv
// Shares one 8-bit ALU between two requesters. Round-robin arbitration,
// ALU_LATENCY cycles in EXEC, then a tagged response held until accepted.
// Optional build macro ULA_ZERO_FLAG_EN adds the registered rsp_zero output.
module ula_arbitro
    import ula_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
`ifdef ULA_ZERO_FLAG_EN
    output logic       rsp_zero,
`endif
    output logic [3:0] alu_controle,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic       alu_carry
);

    if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_latency_range
        $error("ALU_LATENCY must be within 1..15");
    end

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

    state_t     state;
    state_t     next_state;
    logic       ptr;
    logic [3:0] cnt;
    logic [1:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       id_q;
    logic [7:0] result_q;
    logic       carry_q;
    logic       grant_id;
    logic       grant_valid;
    logic       accept;
    logic       done;

    ula_rr_arbitro u_rr (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .ptr         (ptr),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign accept = (state == IDLE) && grant_valid;
    assign done   = (state == RESP) && rsp_ready;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the state-dependent outputs.
    always_comb begin
        next_state   = state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp_valid    = 1'b0;
        alu_controle = CTRL_NONE;
        case (state)
            IDLE: begin
                req0_ready = grant_valid && !grant_id;
                req1_ready = grant_valid && grant_id;
                if (grant_valid) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                alu_controle = op_to_ctrl(op_q);
                if (cnt == 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, latency counter, result capture and pointer update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr      <= 1'b0;
            cnt      <= 4'd0;
            op_q     <= 2'b00;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            id_q     <= 1'b0;
            result_q <= 8'h00;
            carry_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= grant_id ? req1_op : req0_op;
                a_q  <= grant_id ? req1_a  : req0_a;
                b_q  <= grant_id ? req1_b  : req0_b;
                id_q <= grant_id;
                cnt  <= LAT_LOAD;
            end
            if (state == EXEC) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    result_q <= alu_result;
                    // The ALU carry is only meaningful for ADD.
                    carry_q  <= (op_q == OP_ADD) ? alu_carry : 1'b0;
                end
            end
            if (done) begin
                ptr <= ~id_q;
            end
        end
    end

`ifdef ULA_ZERO_FLAG_EN
    logic zero_q;

    // Zero flag captured on the same edge as the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else if (state == EXEC && cnt == 4'd1) begin
            zero_q <= (alu_result == 8'h00);
        end
    end

    assign rsp_zero = zero_q;
`endif

    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// Directed bench for ula_arbitro: a vector table of single requests on a
// latency-1 instance, plus hand sequences for arbitration, response
// back-pressure and reset during EXEC on a latency-4 instance.
module tb_ula_arbitro;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       r0v = 1'b0, r1v = 1'b0, rsp_ready = 1'b1;
    logic [1:0] r0op = 2'b00, r1op = 2'b00;
    logic [7:0] r0a = 8'h00, r0b = 8'h00, r1a = 8'h00, r1b = 8'h00;
    logic       r0r, r1r, rsp_valid, rsp_id, rsp_carry, alu_cy;
    logic [7:0] rsp_result, alu_a, alu_b, alu_res;
    logic [3:0] alu_ctrl;

    logic       rst4 = 1'b1;
    logic       r0v_4 = 1'b0, r1v_4 = 1'b0, rsp_ready_4 = 1'b1;
    logic [1:0] r0op_4 = 2'b00, r1op_4 = 2'b00;
    logic [7:0] r0a_4 = 8'h00, r0b_4 = 8'h00, r1a_4 = 8'h00, r1b_4 = 8'h00;
    logic       r0r_4, r1r_4, rsp_valid_4, rsp_id_4, rsp_carry_4, alu_cy_4;
    logic [7:0] rsp_result_4, alu_a_4, alu_b_4, alu_res_4;
    logic [3:0] alu_ctrl_4;
`ifdef ULA_ZERO_FLAG_EN
    logic       rsp_zero, rsp_zero_4;
`endif

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    // External ALU model. Non-ADD ops drive carry high so that the
    // controller's carry masking is visible.
    function automatic logic [8:0] alu_model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            4'b0001: return {1'b0, a} + {1'b0, b};
            4'b0010: return {1'b1, a - b};
            4'b0100: return {1'b1, a & b};
            4'b1000: return {1'b1, a | b};
            default: return 9'h000;
        endcase
    endfunction

    assign {alu_cy, alu_res}     = alu_model(alu_ctrl, alu_a, alu_b);
    assign {alu_cy_4, alu_res_4} = alu_model(alu_ctrl_4, alu_a_4, alu_b_4);

    ula_arbitro #(.ALU_LATENCY(1)) u_dut (
        .clock(clock), .reset(reset),
        .req0_valid(r0v), .req0_ready(r0r), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
`ifdef ULA_ZERO_FLAG_EN
        .rsp_zero(rsp_zero),
`endif
        .alu_controle(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_res), .alu_carry(alu_cy)
    );

    ula_arbitro #(.ALU_LATENCY(4)) u_dut4 (
        .clock(clock), .reset(rst4),
        .req0_valid(r0v_4), .req0_ready(r0r_4), .req0_op(r0op_4), .req0_a(r0a_4), .req0_b(r0b_4),
        .req1_valid(r1v_4), .req1_ready(r1r_4), .req1_op(r1op_4), .req1_a(r1a_4), .req1_b(r1b_4),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4), .rsp_id(rsp_id_4),
        .rsp_result(rsp_result_4), .rsp_carry(rsp_carry_4),
`ifdef ULA_ZERO_FLAG_EN
        .rsp_zero(rsp_zero_4),
`endif
        .alu_controle(alu_ctrl_4), .alu_a(alu_a_4), .alu_b(alu_b_4),
        .alu_result(alu_res_4), .alu_carry(alu_cy_4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        bit         who;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] ctrl;
        logic [7:0] res;
        logic       cy;
        logic       zr;
    } vec_t;

    vec_t vecs[8];

    // One request on the latency-1 instance; entered just after a rising
    // edge with the DUT idle and rsp_ready high.
    task automatic do_req(input vec_t v);
        int  n;
        bit  seen;
        if (!v.who) begin r0v = 1'b1; r0op = v.op; r0a = v.a; r0b = v.b; end
        else        begin r1v = 1'b1; r1op = v.op; r1a = v.a; r1b = v.b; end
        @(negedge clock);
        check("grant_ready", v.who ? r1r : r0r, 1);
        check("other_ready", v.who ? r0r : r1r, 0);
        tick();
        r0v = 1'b0;
        r1v = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            n++;
            if (i == 0) check("exec_ctrl", alu_ctrl, v.ctrl);
            if (rsp_valid) seen = 1'b1;
        end
        check("latency", n, 2);
        check("rsp_id", rsp_id, v.who);
        check("rsp_result", rsp_result, v.res);
        check("rsp_carry", rsp_carry, v.cy);
        check("resp_ctrl_off", alu_ctrl, 0);
`ifdef ULA_ZERO_FLAG_EN
        check("rsp_zero", rsp_zero, v.zr);
`endif
        @(negedge clock);
        check("rsp_pulse", rsp_valid, 0);
        tick();
    endtask

    initial begin
        int  n;
        bit  seen;
        int  hits;
        bit  exp_id;

        vecs[0] = '{1'b0, 2'b00, 8'hF0, 8'h20, 4'b0001, 8'h10, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 8'h00, 8'h01, 4'b0010, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 2'b10, 8'hCC, 8'hAA, 4'b0100, 8'h88, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 2'b11, 8'hCC, 8'hAA, 4'b1000, 8'hEE, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 2'b00, 8'hFF, 8'h01, 4'b0001, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 2'b00, 8'h01, 8'h01, 4'b0001, 8'h02, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'b10, 8'h0F, 8'hF0, 4'b0100, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 2'b01, 8'h05, 8'h03, 4'b0010, 8'h02, 1'b0, 1'b0};

        // Reset values, inputs idle.
        #12;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_carry", rsp_carry, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_ready", {r0r, r1r}, 0);
`ifdef ULA_ZERO_FLAG_EN
        check("rst_rsp_zero", rsp_zero, 0);
`endif
        tick();
        reset = 1'b0;
        rst4 = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) do_req(vecs[i]);

        // Both valid continuously after a fresh reset: grants 0,1,0,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        r0v = 1'b1; r0op = 2'b10; r0a = 8'hCC; r0b = 8'hAA;
        r1v = 1'b1; r1op = 2'b11; r1a = 8'hCC; r1b = 8'hAA;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clock);
                if (r0r || r1r) seen = 1'b1;
            end
            check("rr_grant_seen", seen, 1);
            check("rr_grant_id", {r0r, r1r}, exp_id ? 2'b01 : 2'b10);
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clock);
                if (rsp_valid) seen = 1'b1;
            end
            check("rr_rsp_id", rsp_id, exp_id);
            check("rr_rsp_result", rsp_result, exp_id ? 8'hEE : 8'h88);
        end
        tick();
        r0v = 1'b0;
        r1v = 1'b0;
        tick();

        // Back-pressure: response held 5 cycles, no grant meanwhile.
        rsp_ready = 1'b0;
        r0v = 1'b1; r0op = 2'b00; r0a = 8'h10; r0b = 8'h20;
        @(negedge clock);
        check("bp_grant", r0r, 1);
        tick();
        r0v = 1'b0;
        r1v = 1'b1; r1op = 2'b11; r1a = 8'h01; r1b = 8'h02;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (rsp_valid) seen = 1'b1;
        end
        check("bp_rsp_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_result", rsp_result, 8'h30);
            check("bp_hold_id", rsp_id, 0);
            check("bp_no_ready", r1r, 0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clock);
        check("bp_release_valid", rsp_valid, 1);
        tick();
        @(negedge clock);
        check("bp_idle_valid", rsp_valid, 0);
        check("bp_idle_grant", r1r, 1);
        tick();
        r1v = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (rsp_valid) seen = 1'b1;
        end
        check("bp_next_id", rsp_id, 1);
        check("bp_next_result", rsp_result, 8'h03);
        tick();

        // Latency-4 instance: reset during EXEC discards the operation.
        r0v_4 = 1'b1; r0op_4 = 2'b00; r0a_4 = 8'h01; r0b_4 = 8'h02;
        @(negedge clock);
        check("l4_grant", r0r_4, 1);
        tick();
        r0v_4 = 1'b0;
        @(negedge clock);
        check("l4_exec_ctrl", alu_ctrl_4, 4'b0001);
        @(negedge clock);
        check("l4_exec_ctrl2", alu_ctrl_4, 4'b0001);
        check("l4_exec_novalid", rsp_valid_4, 0);
        #2;
        rst4 = 1'b1;
        #1;
        check("l4_rst_ctrl", alu_ctrl_4, 0);
        check("l4_rst_a", alu_a_4, 0);
        check("l4_rst_b", alu_b_4, 0);
        check("l4_rst_valid", rsp_valid_4, 0);
        check("l4_rst_result", rsp_result_4, 0);
        tick();
        rst4 = 1'b0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (rsp_valid_4) hits++;
        end
        check("l4_no_rsp", hits, 0);
        tick();
        r0v_4 = 1'b1; r0op_4 = 2'b00; r0a_4 = 8'h01; r0b_4 = 8'h02;
        r1v_4 = 1'b1; r1op_4 = 2'b11; r1a_4 = 8'hF0; r1b_4 = 8'h0F;
        @(negedge clock);
        check("l4_ptr0_grant", {r0r_4, r1r_4}, 2'b10);
        tick();
        r0v_4 = 1'b0;
        r1v_4 = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            n++;
            if (rsp_valid_4) seen = 1'b1;
        end
        check("l4_latency", n, 5);
        check("l4_rsp_id", rsp_id_4, 0);
        check("l4_rsp_result", rsp_result_4, 8'h03);
        check("l4_rsp_carry", rsp_carry_4, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
